// File: rtl/mips_data_memory.sv
// mips_data_memory: word-organised data memory with combinational read and synchronous write
//   CLK  in   1   clock, all state changes on the rising edge
//   RST  in   1   synchronous active-high reset, clears every word, overrides WE
//   A    in  32   byte address, word index = A[31:2], A[1:0] ignored
//   WD   in  32   write data
//   WE   in   1   write enable
//   RD   out 32   read data, combinational from A, zero when out of range
module mips_data_memory #(
    parameter int LOCATIONS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD
);
    localparam int AW = (LOCATIONS > 1) ? $clog2(LOCATIONS) : 1;
    logic [LOCATIONS-1:0][31:0] mem_q, mem_d;
    logic [31:0] idx;
    logic [AW-1:0] ai;
    logic in_range;
    logic unused_lo;
    assign idx = {2'b00, A[31:2]};
    assign ai = idx[AW-1:0];
    // Full-width compare so indices past the array never alias onto low words
    assign in_range = idx < 32'(LOCATIONS);
    assign unused_lo = ^A[1:0];
    assign RD = in_range ? mem_q[ai] : 32'h0;
    always_comb begin
        mem_d = mem_q;
        if (WE && in_range) mem_d[ai] = WD;
    end
    always_ff @(posedge CLK) begin
        mem_q <= RST ? '0 : mem_d;
    end
endmodule

// File: tb/tb_mips_data_memory.sv
// tb_mips_data_memory: directed scoreboard bench for mips_data_memory
module tb_mips_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] wd  = '0;
    logic        we  = 1'b0;
    logic [31:0] rd;
    logic [31:0] exp_q[$];
    int pass_cnt = 0;
    int total = 0;

    mips_data_memory #(.LOCATIONS(256)) dut (
        .CLK(clk), .RST(rst), .A(a), .WD(wd), .WE(we), .RD(rd)
    );

    always #5 clk = ~clk;

    task automatic drive_read(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        a = addr;
        exp_q.push_back(exp);
    endtask

    task automatic compare(input string tag);
        logic [31:0] e;
        #1;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %h", tag, rd);
        end else begin
            e = exp_q.pop_front();
            assert (rd === e) pass_cnt++;
            else $error("FAIL %s: observed %h expected %h", tag, rd, e);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive_read(addr, exp);
        compare(tag);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic r);
        @(negedge clk);
        a = addr;
        wd = data;
        we = 1'b1;
        rst = r;
        @(posedge clk);
        #1;
        we = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        // reset first: contents before reset are undefined
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rd_chk("rst_a0", 32'd0, 32'h0);
        rd_chk("rst_a4", 32'd4, 32'h0);
        rd_chk("rst_a12", 32'd12, 32'h0);
        rd_chk("rst_a1020", 32'd1020, 32'h0);

        wr(32'd4, 32'hA5A5A5A5, 1'b0);
        rd_chk("wr_a4", 32'd4, 32'hA5A5A5A5);
        rd_chk("lo_a5", 32'd5, 32'hA5A5A5A5);
        rd_chk("lo_a6", 32'd6, 32'hA5A5A5A5);
        rd_chk("lo_a7", 32'd7, 32'hA5A5A5A5);

        wr(32'd8, 32'h5A5A5A5A, 1'b0);
        rd_chk("wr_a8", 32'd8, 32'h5A5A5A5A);
        rd_chk("keep_a4", 32'd4, 32'hA5A5A5A5);
        rd_chk("empty_a12", 32'd12, 32'h0);

        @(negedge clk);
        a = 32'd8;
        wd = 32'hFFFFFFFF;
        we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_read(32'd8, 32'h5A5A5A5A);
            compare("hold_a8");
        end

        wr(32'd1024, 32'hDEADBEEF, 1'b0);
        rd_chk("oor_a1024", 32'd1024, 32'h0);
        rd_chk("nowrap_a0", 32'd0, 32'h0);
        rd_chk("nowrap_a1020", 32'd1020, 32'h0);

        wr(32'd4, 32'h12345678, 1'b1);
        rd_chk("rstpri_a4", 32'd4, 32'h0);
        rd_chk("rstpri_a8", 32'd8, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL timeout: bench did not finish, observed hang expected completion");
    end
endmodule
